paper_sequencer: RTL and testbench
==================================

Name: paper_sequencer

Overview:
- Instruction sequencer for the paper processor. Fetches 2-bit-opcode instructions from an external synchronous program memory and decodes them.
- Executes INC/DEC on an internal bank of small registers, resolves JNO branches, and stops on STP.
- Replaces the ad-hoc pulser/mn chaining between the increment, decrement and jump units with one clocked FSM.
- Emits a one-cycle step pulse per retired instruction, the clocked equivalent of mn.

Parameters:
- DW, 2, register data width; arithmetic is modulo 2^DW.
- NREG, 4, number of registers.
- RW, 2, register-select width; NREG <= 2^RW.
- AW, 4, program-counter / instruction-address width.
- IW, 2+RW+AW, instruction width, derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin execution at address 0; honoured only in IDLE or HALT.
- imem_rd  output  1  program-memory read strobe.
- imem_addr  output  AW  program-memory address (the PC).
- imem_data  input  IW  instruction {op[1:0], reg[RW-1:0], tgt[AW-1:0]}, valid the cycle after imem_rd.
- ld_en  input  1  register preload strobe; honoured only in IDLE or HALT.
- ld_sel  input  RW  preload register index.
- ld_data  input  DW  preload value.
- dbg_sel  input  RW  debug read index.
- dbg_value  output  DW  combinational read of reg[dbg_sel].
- busy  output  1  high in FETCH, EXEC and WB.
- halted  output  1  high in HALT.
- step_pulse  output  1  one-cycle pulse per retired instruction.
- fault  output  1  sticky; set when an instruction selects a register >= NREG.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, pc=0, all registers=0.
  - imem_rd=0, busy=0, halted=0, step_pulse=0, fault=0.
- Opcodes:
  - 00 INC: reg += 1, wraps (2^DW-1)+1 -> 0.
  - 01 DEC: reg -= 1, wraps 0-1 -> 2^DW-1.
  - 10 JNO: if reg != 0, pc = tgt; else pc = pc+1.
  - 11 STP: halt; pc is left unchanged.
- States: IDLE, FETCH, EXEC, WB, HALT.
  - IDLE: start -> FETCH with pc=0.
  - FETCH: imem_rd=1, imem_addr=pc; always -> EXEC (1-cycle memory latency).
  - EXEC: latch imem_data into an internal instruction register and read the selected register.
    - reg field >= NREG: set fault, -> HALT; no write, no step_pulse.
    - otherwise: compute the result and next pc; -> WB.
  - WB:
    - Write the register (INC/DEC only).
    - Update pc; pc+1 wraps (2^AW-1) -> 0.
    - Assert step_pulse for this one cycle.
    - -> FETCH, or -> HALT if the op was STP.
  - HALT: halted=1; start -> FETCH with pc=0; fault is cleared on that start.
- Latency: exactly 3 cycles per instruction (FETCH, EXEC, WB). step_pulse recurs every 3 cycles during a run.
- Program start: the first imem_rd rises the cycle after start is sampled in IDLE/HALT.
- start asserted while busy: ignored; no restart.
- ld_en while busy: ignored.
- ld_en in IDLE/HALT: writes ld_data into reg[ld_sel] on that edge; ld_sel >= NREG is ignored.
- ld_en and start in the same cycle: the load takes effect first, and the run sees the loaded value.
- JNO with tgt == pc and reg != 0: legal busy loop; no special handling.
- rst mid-instruction: immediate return to the reset state; no partial register write survives.
- Registers keep their values across HALT -> start. Only rst clears them.

Decomposition:
- Package paper_pkg:
  - opcode constants OP_INC=2'b00, OP_DEC=2'b01, OP_JNO=2'b10, OP_STP=2'b11;
  - state encoding constants;
  - field-extraction helper functions for the instruction word.
- One natural sub-module: paper_regfile (NREG x DW). One synchronous write port shared by preload and WB, muxed by state. Two combinational read ports (execute, debug).
- The FSM, PC and arithmetic stay in paper_sequencer.

Test Plan:
- Reset then idle: after rst deasserts, busy=0, halted=0, imem_rd=0, dbg_value=0 for all 4 registers.
- INC wrap: preload r1=3; program [INC r1, STP]; start -> r1=0, exactly 2 step_pulses, halted=1 with pc=1, 6 cycles from first imem_rd to halted.
- DEC wrap: r0=0; program [DEC r0, STP] -> r0=3, halted=1.
- JNO loop: r2=2; program [DEC r2, JNO r2 tgt=0, STP] -> r2=0, 5 step_pulses (DEC, JNO, DEC, JNO, STP), final pc=2.
- Ignored controls: pulse start and ld_en (r0=1) during a run -> no restart, r0 unchanged. Assert rst during EXEC of INC r3 -> r3=0 and state IDLE on the next cycle.
- Fault with NREG=3: instruction reg=3 -> fault=1, halted=1, no step_pulse. A subsequent start clears fault.

Source files
------------

// File: rtl/paper_pkg.sv
// Shared definitions for the paper processor sequencer: opcodes, FSM encoding
// and instruction-word field extraction.
package paper_pkg;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_JNO = 2'b10;
  localparam logic [1:0] OP_STP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Instruction layout is {op[1:0], reg[rw-1:0], tgt[aw-1:0]}, zero-extended to 32 bits.
  function automatic logic [1:0] instr_op(input logic [31:0] w, input int rw, input int aw);
    return 2'(w >> (rw + aw));
  endfunction

  function automatic logic [31:0] instr_reg(input logic [31:0] w, input int rw, input int aw);
    return (w >> aw) & ((32'd1 << rw) - 32'd1);
  endfunction

  function automatic logic [31:0] instr_tgt(input logic [31:0] w, input int aw);
    return w & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/paper_regfile.sv
// NREG x DW register bank: one synchronous write port, combinational execute
// and debug read ports. Out-of-range indices read as zero and never write.
module paper_regfile #(
  parameter int DW   = 2,
  parameter int NREG = 4,
  parameter int RW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [RW-1:0] wsel,
  input  logic [DW-1:0] wdata,
  input  logic [RW-1:0] rsel,
  output logic [DW-1:0] rdata,
  input  logic [RW-1:0] dsel,
  output logic [DW-1:0] ddata
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (int'(wsel) < NREG)) begin
      regs[wsel] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    ddata = '0;
    if (int'(rsel) < NREG) rdata = regs[rsel];
    if (int'(dsel) < NREG) ddata = regs[dsel];
  end

endmodule

// File: rtl/paper_sequencer.sv
// Fetch/execute/write-back sequencer for the paper processor. Each instruction
// takes exactly FETCH, EXEC, WB; step_pulse marks the WB cycle.
module paper_sequencer
  import paper_pkg::*;
#(
  parameter int DW   = 2,
  parameter int NREG = 4,
  parameter int RW   = 2,
  parameter int AW   = 4,
  localparam int IW  = 2 + RW + AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic          ld_en,
  input  logic [RW-1:0] ld_sel,
  input  logic [DW-1:0] ld_data,
  input  logic [RW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_value,
  output logic          busy,
  output logic          halted,
  output logic          step_pulse,
  output logic          fault,
  output logic [2:0]    dbg_state
);

  state_t        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] npc_q;
  logic [DW-1:0] res_q;
  logic [1:0]    ir_op;
  logic [RW-1:0] ir_reg;

  logic [1:0]    ex_op;
  logic [RW-1:0] ex_reg;
  logic [AW-1:0] ex_tgt;
  logic          ex_ok;
  logic [DW-1:0] ex_val;
  logic [DW-1:0] ex_result;
  logic [AW-1:0] ex_npc;

  logic          idle_like;
  logic          wb_we;
  logic          ld_we;
  logic          rf_we;
  logic [RW-1:0] rf_wsel;
  logic [DW-1:0] rf_wdata;

  assign imem_addr = pc;
  assign dbg_state = state;

  assign ex_op  = instr_op(32'(imem_data), RW, AW);
  assign ex_reg = RW'(instr_reg(32'(imem_data), RW, AW));
  assign ex_tgt = AW'(instr_tgt(32'(imem_data), AW));
  assign ex_ok  = int'(ex_reg) < NREG;

  always_comb begin
    ex_result = ex_val;
    ex_npc    = pc + AW'(1);
    case (ex_op)
      OP_INC:  ex_result = ex_val + DW'(1);
      OP_DEC:  ex_result = ex_val - DW'(1);
      OP_JNO:  if (ex_val != '0) ex_npc = ex_tgt;
      default: ex_npc = pc;
    endcase
  end

  // Preload and write-back share the single write port; state decides who owns it.
  assign idle_like = (state == ST_IDLE) || (state == ST_HALT);
  assign wb_we     = (state == ST_WB) && ((ir_op == OP_INC) || (ir_op == OP_DEC));
  assign ld_we     = idle_like && ld_en;
  assign rf_we     = wb_we || ld_we;
  assign rf_wsel   = wb_we ? ir_reg : ld_sel;
  assign rf_wdata  = wb_we ? res_q : ld_data;

  paper_regfile #(.DW(DW), .NREG(NREG), .RW(RW)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .wsel  (rf_wsel),
    .wdata (rf_wdata),
    .rsel  (ex_reg),
    .rdata (ex_val),
    .dsel  (dbg_sel),
    .ddata (dbg_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= '0;
      npc_q      <= '0;
      res_q      <= '0;
      ir_op      <= OP_INC;
      ir_reg     <= '0;
      imem_rd    <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      step_pulse <= 1'b0;
      fault      <= 1'b0;
    end else begin
      imem_rd    <= 1'b0;
      step_pulse <= 1'b0;
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state   <= ST_FETCH;
            pc      <= '0;
            imem_rd <= 1'b1;
            busy    <= 1'b1;
            halted  <= 1'b0;
            fault   <= 1'b0;
          end
        end
        ST_FETCH: state <= ST_EXEC;
        ST_EXEC: begin
          ir_op  <= ex_op;
          ir_reg <= ex_reg;
          if (!ex_ok) begin
            fault  <= 1'b1;
            state  <= ST_HALT;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else begin
            res_q      <= ex_result;
            npc_q      <= ex_npc;
            step_pulse <= 1'b1;
            state      <= ST_WB;
          end
        end
        ST_WB: begin
          pc <= npc_q;
          if (ir_op == OP_STP) begin
            state  <= ST_HALT;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else begin
            state   <= ST_FETCH;
            imem_rd <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paper_sequencer.sv
// Directed bench for paper_sequencer: a 4-register instance for the main programs
// and a 3-register instance for the out-of-range register fault.
module tb_paper_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd2;

  logic clk;
  logic rst;

  logic       start, imem_rd, ld_en, busy, halted, step_pulse, fault;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic [1:0] ld_sel, ld_data, dbg_sel, dbg_value;
  logic [2:0] dbg_state;
  logic [7:0] prog [16];

  logic       f_start, f_imem_rd, f_ld_en, f_busy, f_halted, f_step_pulse, f_fault;
  logic [3:0] f_imem_addr;
  logic [7:0] f_imem_data;
  logic [1:0] f_ld_sel, f_ld_data, f_dbg_sel, f_dbg_value;
  logic [2:0] f_dbg_state;
  logic [7:0] f_prog [16];

  int n_tests = 0;
  int n_fail  = 0;

  paper_sequencer #(.DW(2), .NREG(4), .RW(2), .AW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
    .dbg_sel(dbg_sel), .dbg_value(dbg_value), .busy(busy), .halted(halted),
    .step_pulse(step_pulse), .fault(fault), .dbg_state(dbg_state)
  );

  paper_sequencer #(.DW(2), .NREG(3), .RW(2), .AW(4)) dut_f (
    .clk(clk), .rst(rst), .start(f_start), .imem_rd(f_imem_rd), .imem_addr(f_imem_addr),
    .imem_data(f_imem_data), .ld_en(f_ld_en), .ld_sel(f_ld_sel), .ld_data(f_ld_data),
    .dbg_sel(f_dbg_sel), .dbg_value(f_dbg_value), .busy(f_busy), .halted(f_halted),
    .step_pulse(f_step_pulse), .fault(f_fault), .dbg_state(f_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // synchronous program memories, one cycle latency
  always @(posedge clk) begin
    if (imem_rd) imem_data <= prog[imem_addr];
    if (f_imem_rd) f_imem_data <= f_prog[f_imem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] sel, input logic [1:0] exp);
    dbg_sel = sel;
    #1;
    check(tag, 32'(dbg_value), 32'(exp));
  endtask

  // driver tasks
  task automatic load(input logic [1:0] sel, input logic [1:0] val);
    ld_en = 1'b1; ld_sel = sel; ld_data = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic kick(input bit with_ld, input logic [1:0] sel, input logic [1:0] val);
    start = 1'b1; ld_en = with_ld; ld_sel = sel; ld_data = val;
    @(negedge clk);
    start = 1'b0; ld_en = 1'b0;
  endtask

  // Counts step pulses until halted; lat = cycles from first imem_rd to halted.
  task automatic wait_halt(input string tag, output int steps, output int lat);
    int  first;
    bit  seen;
    bit  done;
    steps = 0; lat = -1; first = 0; seen = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (imem_rd && !seen) begin seen = 1; first = c; end
      if (step_pulse) steps++;
      if (halted) begin done = 1; lat = c - first; end
      if (!done) @(negedge clk);
    end
    check({tag, "_halt_reached"}, 32'(done), 32'd1);
  endtask

  task automatic f_wait_halt(input string tag, output int steps);
    bit done;
    steps = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (f_step_pulse) steps++;
      if (f_halted) done = 1;
      else @(negedge clk);
    end
    check({tag, "_halt_reached"}, 32'(done), 32'd1);
  endtask

  initial begin
    int steps, lat;
    rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_sel = '0; ld_data = '0; dbg_sel = '0;
    f_start = 1'b0; f_ld_en = 1'b0; f_ld_sel = '0; f_ld_data = '0; f_dbg_sel = '0;
    for (int i = 0; i < 16; i++) begin prog[i] = 8'hC0; f_prog[i] = 8'hC0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_imem_rd", 32'(imem_rd), 32'd0);
    check("rst_step", 32'(step_pulse), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_pc", 32'(imem_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    for (int r = 0; r < 4; r++) check_reg($sformatf("rst_r%0d", r), 2'(r), 2'd0);

    // INC wrap: r1=3, [INC r1, STP]
    prog[0] = 8'b00_01_0000; prog[1] = 8'b11_00_0000;
    load(2'd1, 2'd3);
    kick(1'b0, 2'd0, 2'd0);
    wait_halt("inc", steps, lat);
    check("inc_steps", 32'(steps), 32'd2);
    check("inc_latency", 32'(lat), 32'd6);
    check("inc_halted", 32'(halted), 32'd1);
    check("inc_busy", 32'(busy), 32'd0);
    check("inc_pc", 32'(imem_addr), 32'd1);
    check_reg("inc_r1", 2'd1, 2'd0);

    // DEC wrap: r0=0, [DEC r0, STP]
    prog[0] = 8'b01_00_0000; prog[1] = 8'b11_00_0000;
    kick(1'b0, 2'd0, 2'd0);
    wait_halt("dec", steps, lat);
    check("dec_steps", 32'(steps), 32'd2);
    check("dec_halted", 32'(halted), 32'd1);
    check_reg("dec_r0", 2'd0, 2'd3);

    // JNO loop: r2=2, [DEC r2, JNO r2 ->0, STP]
    prog[0] = 8'b01_10_0000; prog[1] = 8'b10_10_0000; prog[2] = 8'b11_00_0000;
    load(2'd2, 2'd2);
    kick(1'b0, 2'd0, 2'd0);
    wait_halt("jno", steps, lat);
    check("jno_steps", 32'(steps), 32'd5);
    check("jno_latency", 32'(lat), 32'd15);
    check("jno_pc", 32'(imem_addr), 32'd2);
    check_reg("jno_r2", 2'd2, 2'd0);
    check_reg("jno_r0_kept", 2'd0, 2'd3);

    // load and start in the same cycle: run sees r3=2, INC -> 3
    prog[0] = 8'b00_11_0000; prog[1] = 8'b11_00_0000;
    kick(1'b1, 2'd3, 2'd2);
    wait_halt("ldstart", steps, lat);
    check("ldstart_steps", 32'(steps), 32'd2);
    check_reg("ldstart_r3", 2'd3, 2'd3);

    // start and ld_en during a run are ignored: [INC r0 x3, STP] from r0=0
    prog[0] = 8'b00_00_0000; prog[1] = 8'b00_00_0000; prog[2] = 8'b00_00_0000;
    prog[3] = 8'b11_00_0000;
    load(2'd0, 2'd0);
    kick(1'b0, 2'd0, 2'd0);
    repeat (4) @(negedge clk);
    check("ign_busy_midrun", 32'(busy), 32'd1);
    start = 1'b1; ld_en = 1'b1; ld_sel = 2'd0; ld_data = 2'd1;
    @(negedge clk);
    start = 1'b0; ld_en = 1'b0;
    wait_halt("ign", steps, lat);
    check("ign_steps_after", 32'(steps), 32'd3);
    check("ign_pc", 32'(imem_addr), 32'd3);
    check_reg("ign_r0", 2'd0, 2'd3);

    // reset during EXEC of INC r3
    prog[0] = 8'b00_11_0000; prog[1] = 8'b11_00_0000;
    load(2'd3, 2'd1);
    kick(1'b0, 2'd0, 2'd0);
    @(negedge clk);
    check("rstx_in_exec", 32'(dbg_state), 32'(S_EXEC));
    rst = 1'b1;
    @(negedge clk);
    check("rstx_state", 32'(dbg_state), 32'(S_IDLE));
    check("rstx_busy", 32'(busy), 32'd0);
    check("rstx_step", 32'(step_pulse), 32'd0);
    check_reg("rstx_r3", 2'd3, 2'd0);
    check_reg("rstx_r0", 2'd0, 2'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstx_pc", 32'(imem_addr), 32'd0);

    // fault on the NREG=3 instance: INC r3 selects a missing register
    f_prog[0] = 8'b00_11_0000;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    f_wait_halt("flt", steps);
    check("flt_steps", 32'(steps), 32'd0);
    check("flt_fault", 32'(f_fault), 32'd1);
    check("flt_halted", 32'(f_halted), 32'd1);
    check("flt_busy", 32'(f_busy), 32'd0);
    f_dbg_sel = 2'd3;
    #1;
    check("flt_r3_reads_zero", 32'(f_dbg_value), 32'd0);

    // restart clears fault
    f_prog[0] = 8'b11_00_0000;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    check("flt_clear_on_start", 32'(f_fault), 32'd0);
    check("flt_restart_busy", 32'(f_busy), 32'd1);
    f_wait_halt("flt2", steps);
    check("flt2_steps", 32'(steps), 32'd1);
    check("flt2_fault", 32'(f_fault), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
